// File: rtl/mux_ctrl_pkg.sv
// Shared select encodings and 8b/10b K-code byte values for the control-symbol mux.
// MUXCTRL_EXT_SYMBOLS_EN enables the PAD/EDB/FTS/EIE selections in the decode ROM.
package mux_ctrl_pkg;

    localparam int SEL_W  = 4;
    localparam int BYTE_W = 8;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [BYTE_W-1:0] byte_t;

    localparam sel_t SEL_DATA = 4'b0000;
    localparam sel_t SEL_COM  = 4'b0001;
    localparam sel_t SEL_PAD  = 4'b0010;
    localparam sel_t SEL_SKP  = 4'b0011;
    localparam sel_t SEL_STP  = 4'b0100;
    localparam sel_t SEL_SDP  = 4'b0101;
    localparam sel_t SEL_END  = 4'b0110;
    localparam sel_t SEL_EDB  = 4'b0111;
    localparam sel_t SEL_FTS  = 4'b1000;
    localparam sel_t SEL_IDL  = 4'b1001;
    localparam sel_t SEL_EIE  = 4'b1010;

    localparam byte_t K28_5 = 8'hBC;
    localparam byte_t K23_7 = 8'hF7;
    localparam byte_t K28_0 = 8'h1C;
    localparam byte_t K27_7 = 8'hFB;
    localparam byte_t K28_2 = 8'h5C;
    localparam byte_t K29_7 = 8'hFD;
    localparam byte_t K30_7 = 8'hFE;
    localparam byte_t K28_1 = 8'h3C;
    localparam byte_t K28_3 = 8'h7C;
    localparam byte_t K28_7 = 8'hFC;

    localparam byte_t BYTE_ZERO = 8'h00;

endpackage

// File: rtl/mux_ctrl_kcode_rom.sv
// Combinational select-to-K-code decode. Non-K selections report is_k = 0 and the
// top passes the data byte instead; MUXCTRL_EXT_SYMBOLS_EN gates the extended symbols.
module mux_ctrl_kcode_rom
    import mux_ctrl_pkg::*;
(
    input  logic [3:0] S,
    output logic [7:0] sym,
    output logic       is_k
);

    logic [7:0] sym_s;
    logic       is_k_s;

    // Decode the select into a K-code byte; reserved and DATA codes fall through.
    always_comb begin
        sym_s  = BYTE_ZERO;
        is_k_s = 1'b0;
        case (S)
            SEL_COM: begin sym_s = K28_5; is_k_s = 1'b1; end
            SEL_SKP: begin sym_s = K28_0; is_k_s = 1'b1; end
            SEL_STP: begin sym_s = K27_7; is_k_s = 1'b1; end
            SEL_SDP: begin sym_s = K28_2; is_k_s = 1'b1; end
            SEL_END: begin sym_s = K29_7; is_k_s = 1'b1; end
            SEL_IDL: begin sym_s = K28_3; is_k_s = 1'b1; end
`ifdef MUXCTRL_EXT_SYMBOLS_EN
            SEL_PAD: begin sym_s = K23_7; is_k_s = 1'b1; end
            SEL_EDB: begin sym_s = K30_7; is_k_s = 1'b1; end
            SEL_FTS: begin sym_s = K28_1; is_k_s = 1'b1; end
            SEL_EIE: begin sym_s = K28_7; is_k_s = 1'b1; end
`endif
            default: begin sym_s = BYTE_ZERO; is_k_s = 1'b0; end
        endcase
    end

    assign sym  = sym_s;
    assign is_k = is_k_s;

endmodule

// File: rtl/mux_ctrl.sv
// PCIe control-symbol multiplexer: registers a data byte or K-code plus its K-flag.
// Build option MUXCTRL_EXT_SYMBOLS_EN (in the decode ROM) adds PAD/EDB/FTS/EIE.
module mux_ctrl
    import mux_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_L,
    input  logic       enb,
    input  logic [7:0] data,
    input  logic [3:0] S,
    output logic [7:0] outmux,
    output logic       k_out
);

    logic [7:0] rom_sym_s;
    logic       rom_is_k_s;
    logic [7:0] next_byte_s;
    logic       next_k_s;
    logic [7:0] outmux_r;
    logic       k_out_r;

    mux_ctrl_kcode_rom u_rom (
        .S    (S),
        .sym  (rom_sym_s),
        .is_k (rom_is_k_s)
    );

    // Enable gating and K-code versus data selection ahead of the output register.
    always_comb begin
        next_byte_s = BYTE_ZERO;
        next_k_s    = 1'b0;
        if (!enb) begin
            next_byte_s = BYTE_ZERO;
            next_k_s    = 1'b0;
        end else if (rom_is_k_s) begin
            next_byte_s = rom_sym_s;
            next_k_s    = 1'b1;
        end else begin
            next_byte_s = data;
            next_k_s    = 1'b0;
        end
    end

    // Output register; reset clears both byte and flag without waiting for a clock.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            outmux_r <= BYTE_ZERO;
            k_out_r  <= 1'b0;
        end else begin
            outmux_r <= next_byte_s;
            k_out_r  <= next_k_s;
        end
    end

    assign outmux = outmux_r;
    assign k_out  = k_out_r;

endmodule

// File: tb/tb_mux_ctrl.sv
// Self-checking bench for mux_ctrl: directed scenarios plus randomized traffic
// compared against a table-driven reference model.
module tb_mux_ctrl;

    logic       clk;
    logic       reset_L;
    logic       enb;
    logic [7:0] data;
    logic [3:0] S;
    logic [7:0] outmux;
    logic       k_out;

    int checks;
    int errors;

    logic [7:0] sym_tab [16];
    bit         k_tab   [16];

    mux_ctrl dut (
        .clk     (clk),
        .reset_L (reset_L),
        .enb     (enb),
        .data    (data),
        .S       (S),
        .outmux  (outmux),
        .k_out   (k_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Symbol table straight from the select encoding list.
    task automatic build_model();
        for (int i = 0; i < 16; i++) begin
            sym_tab[i] = 8'h00;
            k_tab[i]   = 1'b0;
        end
        sym_tab[1] = 8'hBC; k_tab[1] = 1'b1;
        sym_tab[3] = 8'h1C; k_tab[3] = 1'b1;
        sym_tab[4] = 8'hFB; k_tab[4] = 1'b1;
        sym_tab[5] = 8'h5C; k_tab[5] = 1'b1;
        sym_tab[6] = 8'hFD; k_tab[6] = 1'b1;
        sym_tab[9] = 8'h7C; k_tab[9] = 1'b1;
`ifdef MUXCTRL_EXT_SYMBOLS_EN
        sym_tab[2]  = 8'hF7; k_tab[2]  = 1'b1;
        sym_tab[7]  = 8'hFE; k_tab[7]  = 1'b1;
        sym_tab[8]  = 8'h3C; k_tab[8]  = 1'b1;
        sym_tab[10] = 8'hFC; k_tab[10] = 1'b1;
`endif
    endtask

    function automatic logic [8:0] model(input logic e, input logic [3:0] s, input logic [7:0] d);
        if (!e)          return {1'b0, 8'h00};
        else if (k_tab[s]) return {1'b1, sym_tab[s]};
        else             return {1'b0, d};
    endfunction

    // Drive at the falling edge, sample just after the next rising edge.
    task automatic drive(input logic e, input logic [3:0] s, input logic [7:0] d);
        @(negedge clk);
        enb = e; S = s; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 4'b0001, 8'h0A);
        @(negedge clk);
        enb = 1'b1; S = 4'b0100; data = 8'h0A;
        reset_L = 1'b0;
        #1;
        checks++;
        if (outmux !== 8'h00 || k_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got %h/%b want 00/0", outmux, k_out);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outmux !== 8'h00 || k_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got %h/%b want 00/0", outmux, k_out);
        end
        @(negedge clk);
        reset_L = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (outmux !== 8'hFB || k_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got %h/%b want fb/1", outmux, k_out);
        end
    endtask

    task automatic test_data_pass();
        drive(1'b1, 4'b0000, 8'h0A);
        checks++;
        if (outmux !== 8'h0A || k_out !== 1'b0) begin
            errors++;
            $display("FAIL data_0a got %h/%b want 0a/0", outmux, k_out);
        end
        @(negedge clk);
        data = 8'h55;
        #1;
        checks++;
        if (outmux !== 8'h0A) begin
            errors++;
            $display("FAIL data_hold got %h want 0a", outmux);
        end
        @(posedge clk);
        #1;
        checks++;
        if (outmux !== 8'h55 || k_out !== 1'b0) begin
            errors++;
            $display("FAIL data_55 got %h/%b want 55/0", outmux, k_out);
        end
    endtask

    task automatic test_framing_sweep();
        logic [3:0] sels [5];
        logic [7:0] exp  [5];
        sels = '{4'b0100, 4'b0101, 4'b0110, 4'b1001, 4'b0011};
        exp  = '{8'hFB, 8'h5C, 8'hFD, 8'h7C, 8'h1C};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, sels[i], 8'h33);
            checks++;
            if (outmux !== exp[i] || k_out !== 1'b1) begin
                errors++;
                $display("FAIL sweep_%0d got %h/%b want %h/1", i, outmux, k_out, exp[i]);
            end
        end
    endtask

    task automatic test_enable();
        logic       en [3];
        logic [7:0] eb [3];
        en = '{1'b1, 1'b0, 1'b1};
        eb = '{8'hBC, 8'h00, 8'hBC};
        for (int i = 0; i < 3; i++) begin
            drive(en[i], 4'b0001, 8'h77);
            checks++;
            if (outmux !== eb[i] || k_out !== en[i]) begin
                errors++;
                $display("FAIL enable_%0d got %h/%b want %h/%b", i, outmux, k_out, eb[i], en[i]);
            end
        end
    endtask

    task automatic test_reserved();
        logic [8:0] e;
        drive(1'b1, 4'b1100, 8'hA5);
        checks++;
        if (outmux !== 8'hA5 || k_out !== 1'b0) begin
            errors++;
            $display("FAIL reserved_c got %h/%b want a5/0", outmux, k_out);
        end
`ifdef MUXCTRL_EXT_SYMBOLS_EN
        e = {1'b1, 8'hFE};
`else
        e = {1'b0, 8'hA5};
`endif
        drive(1'b1, 4'b0111, 8'hA5);
        checks++;
        if ({k_out, outmux} !== e) begin
            errors++;
            $display("FAIL edb_select got %h/%b want %h/%b", outmux, k_out, e[7:0], e[8]);
        end
    endtask

    task automatic test_midstream_reset();
        drive(1'b1, 4'b0110, 8'h11);
        checks++;
        if (outmux !== 8'hFD || k_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got %h/%b want fd/1", outmux, k_out);
        end
        #1;
        reset_L = 1'b0;
        #1;
        checks++;
        if (outmux !== 8'h00 || k_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got %h/%b want 00/0", outmux, k_out);
        end
        @(negedge clk);
        reset_L = 1'b1;
        #1;
        checks++;
        if (outmux !== 8'h00 || k_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_released got %h/%b want 00/0", outmux, k_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (outmux !== 8'hFD || k_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_resume got %h/%b want fd/1", outmux, k_out);
        end
    endtask

    task automatic test_random();
        logic       e;
        logic [3:0] s;
        logic [7:0] d;
        logic [8:0] exp;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 4) != 0);
            s = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            exp = model(e, s, d);
            drive(e, s, d);
            checks++;
            if ({k_out, outmux} !== exp) begin
                errors++;
                $display("FAIL random_%0d e=%b s=%h d=%h got %h/%b want %h/%b",
                         i, e, s, d, outmux, k_out, exp[7:0], exp[8]);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_L = 1'b1;
        enb     = 1'b0;
        S       = 4'b0000;
        data    = 8'h00;
        build_model();
        test_reset();
        test_data_pass();
        test_framing_sweep();
        test_enable();
        test_reserved();
        test_midstream_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
